sipo_collector: RTL and testbench
=================================

// Module: sipo_collector
// PURPOSE
//  Serial-in parallel-out word collector. Receive side of the PISO word serializer.
//  Accepts one DATA_WID word per wSignal cycle into a frame buffer.
//  After MEMORY_WID words, presents the whole frame in parallel and holds it until read.
//  Sits between a serial word stream (e.g. PISO DataOut) and a parallel consumer.
// PARAMETERS
//  DATA_WID    8  width of one word
//  MEMORY_WID  5  words per frame (>=2)
// PORTS
//  clk        in   1                     clock, all logic on rising edge
//  rst        in   1                     synchronous reset, active-high
//  wSignal    in   1                     DataIn valid; word accepted on this edge if allowed
//  DataIn     in   DATA_WID              serial word input
//  rSignal    in   1                     consumer read/acknowledge of a completed frame
//  DataOut    out  DATA_WID*MEMORY_WID   frame; word k at [k*DATA_WID +: DATA_WID]
//  frameValid out  1                     a complete frame is held on DataOut
//  wordCount  out  $clog2(MEMORY_WID+1)  words collected in current frame (0..MEMORY_WID)
//  overflow   out  1                     sticky: a word was dropped while frame full
// BEHAVIOUR
//  - Reset (rst=1 at edge): DataOut=0, frameValid=0, wordCount=0, overflow=0, state=FILL.
//    Reset mid-frame discards all partial data.
//  - All outputs registered. No combinational path from input to output.
//  - FSM states: FILL, FULL.
//  - FILL, wSignal=1:
//    - DataIn written to shadow slot wordCount; wordCount++.
//    - Words in order: first word received -> slot 0 (DataOut LSBs).
//    - If wordCount was MEMORY_WID-1: shadow frame incl. this word copied to DataOut on the
//      same edge, frameValid=1, wordCount=MEMORY_WID, state->FULL.
//    - Latency: last word's edge -> frameValid/DataOut valid 1 cycle later (visible after edge).
//  - FILL, wSignal=0: hold. rSignal ignored in FILL (no effect, no error).
//  - DataOut only updates on frame completion; partial frames never visible on DataOut.
//  - FULL, rSignal=1, wSignal=0: frameValid->0, wordCount->0, state->FILL.
//    DataOut keeps last frame (stale, qualified by frameValid).
//  - FULL, rSignal=1, wSignal=1: frame released. DataIn stored as slot 0 of next frame.
//    wordCount->1, frameValid->0, state->FILL. No word lost.
//  - FULL, rSignal=0, wSignal=1: DataIn dropped, overflow->1. DataOut and wordCount unchanged.
//  - FULL, both 0: hold.
//  - overflow: sticky until rst.
//  - wordCount: wraps only via read. Never exceeds MEMORY_WID.
// TESTING (DATA_WID=8, MEMORY_WID=5)
//  1 Reset -> DataOut=0, frameValid=0, wordCount=0, overflow=0.
//  2 Full frame: wSignal=1 for 5 cycles, DataIn=11,22,33,44,55.
//    -> after 5th edge frameValid=1, DataOut=40'h5544332211, wordCount=5.
//    -> frameValid=0 after every earlier edge.
//  3 Gapped write: words A1,B2 then wSignal=0 for 3 cycles, then C3,D4,E5.
//    -> wordCount holds at 2 during gap, DataOut stays 0.
//    -> final DataOut=40'hE5D4C3B2A1.
//  4 Overflow: from FULL (test 2), wSignal=1 DataIn=FF, rSignal=0.
//    -> overflow=1, DataOut unchanged, wordCount=5.
//  5 Simultaneous: in FULL, rSignal=1 & wSignal=1 DataIn=66.
//    -> frameValid=0, wordCount=1. Next 4 words 77,88,99,AA -> DataOut=40'hAA99887766.
//  6 Reset mid-frame after 3 words, then rSignal=1 in FILL.
//    -> all outputs 0, rSignal has no effect. Next 5 words form a clean frame.

Source files
------------

// File: rtl/sipo_collector_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sipo_collector_if                                            |
// | Description : Word stream in / parallel frame out bundle for the collector |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface sipo_collector_if #(
  parameter int DATA_WID   = 8,
  parameter int MEMORY_WID = 5
);
  localparam int c_CNT_W = $clog2(MEMORY_WID + 1);

  logic                           wSignal;
  logic [DATA_WID-1:0]            DataIn;
  logic                           rSignal;
  logic [DATA_WID*MEMORY_WID-1:0] DataOut;
  logic                           frameValid;
  logic [c_CNT_W-1:0]             wordCount;
  logic                           overflow;

  // master is the stream producer / frame consumer side; slave is the collector
  modport master (
    output wSignal, DataIn, rSignal,
    input  DataOut, frameValid, wordCount, overflow
  );

  modport slave (
    input  wSignal, DataIn, rSignal,
    output DataOut, frameValid, wordCount, overflow
  );
endinterface
`default_nettype wire

// File: rtl/sipo_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sipo_collector                                               |
// | Description : Serial-in parallel-out word collector with frame hold         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sipo_collector #(
  parameter int DATA_WID   = 8,
  parameter int MEMORY_WID = 5
) (
  input  wire              clk,
  input  wire              rst,
  sipo_collector_if.slave  bus
);
  localparam int                c_CNT_W = $clog2(MEMORY_WID + 1);
  localparam int                c_FRM_W = DATA_WID * MEMORY_WID;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(MEMORY_WID - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_FRM_W-1:0]   r_shadow;
  logic [c_FRM_W-1:0]   r_data_out;
  logic                 r_frame_valid;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_overflow;
  logic [c_FRM_W-1:0]   w_frame;

  // Shadow frame with the incoming word already placed in its slot, so the
  // completing word is included when the frame is published on the same edge.
  for (genvar k = 0; k < MEMORY_WID; k++) begin : g_frame
    assign w_frame[k*DATA_WID +: DATA_WID] =
      (r_count == c_CNT_W'(k)) ? bus.DataIn : r_shadow[k*DATA_WID +: DATA_WID];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FILL;
      r_shadow      <= '0;
      r_data_out    <= '0;
      r_frame_valid <= 1'b0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_FILL: begin
          if (bus.wSignal) begin
            r_shadow <= w_frame;
            r_count  <= r_count + 1'b1;
            if (r_count == c_LAST) begin
              r_data_out    <= w_frame;
              r_frame_valid <= 1'b1;
              r_state       <= ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (bus.rSignal) begin
            r_frame_valid <= 1'b0;
            r_state       <= ST_FILL;
            // A write coinciding with the read opens the next frame at slot 0.
            if (bus.wSignal) begin
              r_shadow[DATA_WID-1:0] <= bus.DataIn;
              r_count                <= c_ONE;
            end else begin
              r_count <= '0;
            end
          end else if (bus.wSignal) begin
            r_overflow <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.DataOut    = r_data_out;
  assign bus.frameValid = r_frame_valid;
  assign bus.wordCount  = r_count;
  assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_sipo_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sipo_collector                                            |
// | Description : Directed vector bench for sipo_collector (8-bit, 5 words)     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sipo_collector;
  localparam int DATA_WID   = 8;
  localparam int MEMORY_WID = 5;

  logic clk = 1'b0;
  logic rst;

  sipo_collector_if #(.DATA_WID(DATA_WID), .MEMORY_WID(MEMORY_WID)) bus ();

  sipo_collector #(.DATA_WID(DATA_WID), .MEMORY_WID(MEMORY_WID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        w;
    logic [7:0]  din;
    logic        r;
    logic [39:0] out;
    logic        fv;
    logic [2:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[64];
  int   nvec   = 0;
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic rs, input logic w, input logic [7:0] din, input logic r,
                     input logic [39:0] out, input logic fv, input logic [2:0] cnt,
                     input logic ovf);
    vecs[nvec] = '{rs, w, din, r, out, fv, cnt, ovf};
    nvec++;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %h expected %h", name, got, exp);
  endtask

  // Drive on the falling edge, let one rising edge act, sample on the next falling edge.
  task automatic step(input logic rs, input logic w, input logic [7:0] din, input logic r);
    rst         = rs;
    bus.wSignal = w;
    bus.DataIn  = din;
    bus.rSignal = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [39:0] out, input logic fv,
                           input logic [2:0] cnt, input logic ovf);
    check({tag, ".DataOut"},    64'(bus.DataOut),    64'(out));
    check({tag, ".frameValid"}, 64'(bus.frameValid), 64'(fv));
    check({tag, ".wordCount"},  64'(bus.wordCount),  64'(cnt));
    check({tag, ".overflow"},   64'(bus.overflow),   64'(ovf));
  endtask

  initial begin
    rst = 1'b1; bus.wSignal = 1'b0; bus.DataIn = '0; bus.rSignal = 1'b0;

    // reset state
    add(1, 0, 8'h00, 0, 40'h0, 0, 0, 0);
    // full frame 11..55
    add(0, 1, 8'h11, 0, 40'h0, 0, 1, 0);
    add(0, 1, 8'h22, 0, 40'h0, 0, 2, 0);
    add(0, 1, 8'h33, 0, 40'h0, 0, 3, 0);
    add(0, 1, 8'h44, 0, 40'h0, 0, 4, 0);
    add(0, 1, 8'h55, 0, 40'h5544332211, 1, 5, 0);
    // overflow drop, then hold
    add(0, 1, 8'hFF, 0, 40'h5544332211, 1, 5, 1);
    add(0, 0, 8'h00, 0, 40'h5544332211, 1, 5, 1);
    // simultaneous read+write, then rest of the frame
    add(0, 1, 8'h66, 1, 40'h5544332211, 0, 1, 1);
    add(0, 1, 8'h77, 0, 40'h5544332211, 0, 2, 1);
    add(0, 1, 8'h88, 0, 40'h5544332211, 0, 3, 1);
    add(0, 1, 8'h99, 0, 40'h5544332211, 0, 4, 1);
    add(0, 1, 8'hAA, 0, 40'hAA99887766, 1, 5, 1);
    // plain read leaves stale data
    add(0, 0, 8'h00, 1, 40'hAA99887766, 0, 0, 1);
    add(1, 0, 8'h00, 0, 40'h0, 0, 0, 0);
    // gapped write
    add(0, 1, 8'hA1, 0, 40'h0, 0, 1, 0);
    add(0, 1, 8'hB2, 0, 40'h0, 0, 2, 0);
    add(0, 0, 8'h00, 0, 40'h0, 0, 2, 0);
    add(0, 0, 8'hEE, 0, 40'h0, 0, 2, 0);
    add(0, 0, 8'h00, 0, 40'h0, 0, 2, 0);
    add(0, 1, 8'hC3, 0, 40'h0, 0, 3, 0);
    add(0, 1, 8'hD4, 0, 40'h0, 0, 4, 0);
    add(0, 1, 8'hE5, 0, 40'hE5D4C3B2A1, 1, 5, 0);
    // reset mid-frame, rSignal ignored in FILL, clean frame afterwards
    add(1, 0, 8'h00, 0, 40'h0, 0, 0, 0);
    add(0, 1, 8'h11, 0, 40'h0, 0, 1, 0);
    add(0, 1, 8'h22, 0, 40'h0, 0, 2, 0);
    add(0, 1, 8'h33, 0, 40'h0, 0, 3, 0);
    add(1, 0, 8'h00, 0, 40'h0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 40'h0, 0, 0, 0);
    add(0, 1, 8'h01, 0, 40'h0, 0, 1, 0);
    add(0, 1, 8'h02, 1, 40'h0, 0, 2, 0);
    add(0, 1, 8'h03, 0, 40'h0, 0, 3, 0);
    add(0, 1, 8'h04, 0, 40'h0, 0, 4, 0);
    add(0, 1, 8'h05, 0, 40'h0504030201, 1, 5, 0);

    @(negedge clk);
    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].rst, vecs[i].w, vecs[i].din, vecs[i].r);
      check_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].fv, vecs[i].cnt, vecs[i].ovf);
    end

    // Repeated drops while full: frame and count frozen, overflow set.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'hC0 + 8'(i), 0);
      check_all($sformatf("drop%0d", i), 40'h0504030201, 1, 5, 1);
    end
    // Overflow survives a read and a whole new frame.
    step(0, 0, 8'h00, 1);
    check_all("rel", 40'h0504030201, 0, 0, 1);
    for (int i = 0; i < MEMORY_WID; i++) begin
      step(0, 1, 8'h10 * 8'(i + 1) + 8'h0F, 0);
    end
    check_all("refill", 40'h5F4F3F2F1F, 1, 5, 1);
    step(1, 0, 8'h00, 0);
    check_all("final_rst", 40'h0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
